// File: rtl/fetch_stage.sv
// Purpose: IF stage of a 5-stage pipeline; owns the PC, the IF/ID register and the fetch counter.
// Latency: one cycle from an imem_ready word to IF/ID; a redirect moves the PC one cycle after its pulse.
// Backpressure: stall_f holds the PC and IF/ID; imem_ready=0 holds the PC and feeds bubbles downstream.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall_f,
    input  logic        i_flush_d,
    input  logic        i_pc_src_e,
    input  logic [31:0] i_branch_target_e,
    input  logic        i_jump_d,
    input  logic [31:0] i_jump_target_d,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_ready,
    output logic [31:0] o_pc_f,
    output logic [31:0] o_instr_d,
    output logic [31:0] o_pc_plus4_d,
    output logic        o_valid_d,
    output logic [31:0] o_fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_FETCH      = 2'd1,
        S_WAIT       = 2'd2,
        S_WAIT_REDIR = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;
    logic [31:0] r_count;

    logic        w_redir;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;
    logic [31:0] w_pc_next;
    logic        w_take;
    logic        w_bubble;

    // Branch resolved in EX is older than a jump in ID, so it wins outright.
    assign w_redir  = i_pc_src_e | i_jump_d;
    assign w_target = i_pc_src_e ? i_branch_target_e : i_jump_target_d;
    assign w_pc_inc = r_pc + 32'd4;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:       w_state_next = S_FETCH;
            S_FETCH:      if (!i_imem_ready) w_state_next = w_redir ? S_WAIT_REDIR : S_WAIT;
            S_WAIT: begin
                if (i_imem_ready)  w_state_next = S_FETCH;
                else if (w_redir)  w_state_next = S_WAIT_REDIR;
            end
            S_WAIT_REDIR: if (i_imem_ready) w_state_next = S_FETCH;
            default:      w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pc_next = r_pc;
        w_take    = 1'b0;
        w_bubble  = 1'b0;
        case (r_state)
            S_FETCH, S_WAIT: begin
                if (w_redir) begin
                    w_pc_next = w_target;
                    w_bubble  = 1'b1;
                end else if (i_stall_f) begin
                    w_bubble  = i_flush_d;
                end else if (!i_imem_ready) begin
                    w_bubble  = 1'b1;
                end else begin
                    w_pc_next = w_pc_inc;
                    w_take    = !i_flush_d;
                    w_bubble  = i_flush_d;
                end
            end
            // IDLE and WAIT_REDIR never accept a word: IF/ID is already a bubble,
            // and in WAIT_REDIR the arriving word belongs to the abandoned path.
            default: begin
                if (w_redir) w_pc_next = w_target;
                w_bubble = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
            r_count    <= 32'd0;
        end else begin
            r_pc <= w_pc_next;
            if (w_take) begin
                r_instr    <= i_imem_rdata;
                r_pc_plus4 <= w_pc_inc;
                r_valid    <= 1'b1;
                r_count    <= r_count + 32'd1;
            end else if (w_bubble) begin
                r_instr    <= NOP_INSTR;
                r_pc_plus4 <= 32'd0;
                r_valid    <= 1'b0;
            end
        end
    end

    assign o_imem_addr   = r_pc;
    assign o_pc_f        = r_pc;
    assign o_instr_d     = r_instr;
    assign o_pc_plus4_d  = r_pc_plus4;
    assign o_valid_d     = r_valid;
    assign o_fetch_count = r_count;

endmodule
